// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and divisor helper for the UART link.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PAR,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   // Clock cycles per line bit, rounded to nearest.
   function automatic int div_calc(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, start-bit qualification, centre sampling, parity/stop check.
// Latency: rd_vld about DIV*(DATA_BITS+P+1.5)+3 cycles after the start-bit falling edge.
// Backpressure: none; rd_vld is a one-cycle pulse that must be consumed when it fires.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DIV       = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_EVEN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 rd_vld,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_perr,
   output logic                 rd_ferr
);

   localparam int DCW = $clog2(DIV);
   localparam int BCW = $clog2(DATA_BITS);
   localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
   localparam logic [DCW-1:0] DIV_HALF  = DCW'(DIV / 2);
   localparam logic [BCW-1:0] DBIT_LAST = BCW'(DATA_BITS - 1);

   logic                 rx_s1, rx_s2, rx_prev;
   rx_state_t            rx_state;
   logic [DCW-1:0]       baud_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_smp;
   logic                 perr;

   // Synchronise rx and keep one more stage for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Parity mismatch against the sampled parity bit; never flagged without parity.
   always_comb begin
      perr = 1'b0;
      if (PARITY == PAR_EVEN)
         perr = par_smp ^ (^shreg);
      else if (PARITY == PAR_ODD)
         perr = par_smp ^ (~^shreg);
   end

   // Receive FSM: the start re-sample at DIV/2 restarts the counter so later samples land mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_smp  <= 1'b0;
         rd_vld   <= 1'b0;
         rd_data  <= '0;
         rd_perr  <= 1'b0;
         rd_ferr  <= 1'b0;
      end else begin
         rd_vld <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  baud_cnt <= '0;
               end
            end
            RX_START: begin
               if (baud_cnt == DIV_HALF) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               if (baud_cnt != DIV_LAST) begin
                  baud_cnt <= baud_cnt + 1'b1;
               end else begin
                  baud_cnt <= '0;
                  case (rx_state)
                     RX_DATA: begin
                        shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DBIT_LAST)
                           rx_state <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                        else
                           bit_cnt <= bit_cnt + 1'b1;
                     end
                     RX_PAR: begin
                        par_smp  <= rx_s2;
                        rx_state <= RX_STOP;
                     end
                     RX_STOP: begin
                        rd_vld   <= 1'b1;
                        rd_data  <= shreg;
                        rd_perr  <= perr;
                        rd_ferr  <= ~rx_s2;
                        rx_state <= RX_IDLE;
                     end
                     default: rx_state <= RX_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_txrx.sv
// Full-duplex UART: sends one CMD_WIDTH command as back-to-back frames MSW first; receives frames independently.
// Latency: start bit on tx the cycle after the transfer; cmd_rdy returns one cycle after the last stop bit.
// Backpressure: cmd_rdy low for the whole command; receive side has none (pulsed rd_vld).
module uart_frame_txrx
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int CMD_WIDTH = 16,
   parameter int PARITY    = PAR_EVEN,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CMD_WIDTH-1:0] cmd_in,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   output logic                 tx,
   input  logic                 rx,
   output logic                 rd_vld,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_perr,
   output logic                 rd_ferr
);

   localparam int DIV    = div_calc(CLK_HZ, BAUD);
   localparam int NWORDS = CMD_WIDTH / DATA_BITS;
   localparam int DCW    = $clog2(DIV);
   localparam int BCW    = $clog2(DATA_BITS + 1);
   localparam int WCW    = $clog2(NWORDS + 1);
   localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
   localparam logic [BCW-1:0] DBIT_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] SBIT_LAST = BCW'(STOP_BITS - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);

   if (CMD_WIDTH == 0 || CMD_WIDTH % DATA_BITS != 0) begin : g_bad_cmd_width
      $error("CMD_WIDTH must be a nonzero multiple of DATA_BITS");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("DATA_BITS must be 5..9");
   end
   if (DIV < 4) begin : g_bad_div
      $error("baud divisor must be at least 4");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
      $error("PARITY must be 0, 1 or 2");
   end

   tx_state_t            tx_state;
   logic [DCW-1:0]       baud_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [WCW-1:0]       word_cnt;
   logic [CMD_WIDTH-1:0] shreg;
   logic [DATA_BITS-1:0] cur_word;
   logic [DATA_BITS-1:0] wsh;
   logic                 par_bit;

   // Word on the wire is always the top slice; shreg shifts up after each frame.
   always_comb begin
      cur_word = shreg[CMD_WIDTH-1 -: DATA_BITS];
      par_bit  = (PARITY == PAR_ODD) ? ~^cur_word : ^cur_word;
   end

   // Transmit FSM; tx is registered and set on each bit boundary so the line never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         shreg    <= '0;
         wsh      <= '0;
         cmd_rdy  <= 1'b1;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (cmd_vld && cmd_rdy) begin
                  shreg    <= cmd_in;
                  tx_state <= TX_START;
                  baud_cnt <= '0;
                  word_cnt <= '0;
                  cmd_rdy  <= 1'b0;
                  tx       <= 1'b0;
               end
            end
            default: begin
               if (baud_cnt != DIV_LAST) begin
                  baud_cnt <= baud_cnt + 1'b1;
               end else begin
                  baud_cnt <= '0;
                  case (tx_state)
                     TX_START: begin
                        tx_state <= TX_DATA;
                        bit_cnt  <= '0;
                        tx       <= cur_word[0];
                        wsh      <= cur_word >> 1;
                     end
                     TX_DATA: begin
                        if (bit_cnt == DBIT_LAST) begin
                           bit_cnt <= '0;
                           if (PARITY != PAR_NONE) begin
                              tx_state <= TX_PAR;
                              tx       <= par_bit;
                           end else begin
                              tx_state <= TX_STOP;
                              tx       <= 1'b1;
                           end
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                           tx      <= wsh[0];
                           wsh     <= wsh >> 1;
                        end
                     end
                     TX_PAR: begin
                        tx_state <= TX_STOP;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                     end
                     TX_STOP: begin
                        if (bit_cnt == SBIT_LAST) begin
                           bit_cnt <= '0;
                           shreg   <= shreg << DATA_BITS;
                           if (word_cnt == WORD_LAST) begin
                              tx_state <= TX_IDLE;
                              cmd_rdy  <= 1'b1;
                              tx       <= 1'b1;
                           end else begin
                              tx_state <= TX_START;
                              word_cnt <= word_cnt + 1'b1;
                              tx       <= 1'b0;
                           end
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                        end
                     end
                     default: begin
                        tx_state <= TX_IDLE;
                        cmd_rdy  <= 1'b1;
                        tx       <= 1'b1;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   uart_rx_core #(
      .DIV       (DIV),
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rd_vld  (rd_vld),
      .rd_data (rd_data),
      .rd_perr (rd_perr),
      .rd_ferr (rd_ferr)
   );

endmodule

// File: tb/tb_uart_frame_txrx.sv
// Directed bench for uart_frame_txrx: default link plus a 7-bit/odd/2-stop instance in loopback.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_frame_txrx;

   localparam int DIV1 = 434;
   localparam int DIV2 = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd_in;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        tx;
   logic        rx;
   logic        rd_vld;
   logic [7:0]  rd_data;
   logic        rd_perr;
   logic        rd_ferr;
   logic        rx_drv;
   logic        loop_en;

   logic [13:0] cmd2_in;
   logic        cmd2_vld;
   logic        cmd2_rdy;
   logic        tx2;
   logic        rd2_vld;
   logic [6:0]  rd2_data;
   logic        rd2_perr;
   logic        rd2_ferr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [9:0] rxq[$];
   int         rxt[$];
   logic [8:0] rx2q[$];

   assign rx = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rd_vld) begin
         rxq.push_back({rd_ferr, rd_perr, rd_data});
         rxt.push_back(cyc);
      end
      if (rd2_vld) rx2q.push_back({rd2_ferr, rd2_perr, rd2_data});
   end

   uart_frame_txrx dut (
      .clk     (clk),
      .rst     (rst),
      .cmd_in  (cmd_in),
      .cmd_vld (cmd_vld),
      .cmd_rdy (cmd_rdy),
      .tx      (tx),
      .rx      (rx),
      .rd_vld  (rd_vld),
      .rd_data (rd_data),
      .rd_perr (rd_perr),
      .rd_ferr (rd_ferr)
   );

   uart_frame_txrx #(
      .CLK_HZ    (50_000_000),
      .BAUD      (5_000_000),
      .DATA_BITS (7),
      .CMD_WIDTH (14),
      .PARITY    (2),
      .STOP_BITS (2)
   ) dut2 (
      .clk     (clk),
      .rst     (rst),
      .cmd_in  (cmd2_in),
      .cmd_vld (cmd2_vld),
      .cmd_rdy (cmd2_rdy),
      .tx      (tx2),
      .rx      (tx2),
      .rd_vld  (rd2_vld),
      .rd_data (rd2_data),
      .rd_perr (rd2_perr),
      .rd_ferr (rd2_ferr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one 8-bit even-parity-style frame on rx_drv: start, data LSB first, parity, stop.
   task automatic drive_frame(input logic [7:0] d, input logic pbit, input logic sbit);
      logic [10:0] bits;
      bits = {sbit, pbit, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_drv = bits[i];
         repeat (DIV1) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   logic [21:0] line;
   logic [13:0] c2 [2];
   logic [21:0] e2 [2];
   logic [15:0] cmds [3];
   int          tk [3];
   int          n;
   int          fall_cyc;
   int          lat;

   initial begin
      rst = 1'b1; cmd_in = '0; cmd_vld = 1'b0; cmd2_in = '0; cmd2_vld = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_rdy", cmd_rdy, 1'b1);
      chk("rst_vld", rd_vld, 1'b0);
      chk("rst_data", rd_data, 8'h00);
      chk("rst_perr", rd_perr, 1'b0);
      chk("rst_ferr", rd_ferr, 1'b0);
      chk("rst_tx2", tx2, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Default instance: 0xA53C as two frames, exact bit timing and cmd_rdy return.
      cmd_in = 16'hA53C; cmd_vld = 1'b1; line = '0;
      for (int c = 1; c <= 9549; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("t1_rdy_low", cmd_rdy, 1'b0);
            chk("t1_start", tx, 1'b0);
            cmd_vld = 1'b0; cmd_in = 16'hFFFF;
         end
         if (c == 434) chk("t1_start_end", tx, 1'b0);
         if (c == 435) chk("t1_bit0", tx, 1'b1);
         if ((c - 1) % DIV1 == DIV1 / 2 && (c - 1) / DIV1 < 22) line[(c - 1) / DIV1] = tx;
         if (c == 9548) begin
            chk("t1_rdy_9548", cmd_rdy, 1'b0);
            chk("t1_stop_9548", tx, 1'b1);
         end
         if (c == 9549) chk("t1_rdy_9549", cmd_rdy, 1'b1);
      end
      chk("t1_line", line, 22'b10001111000_10101001010);
      chk("t1_no_rx", rxq.size(), 0);

      // 7-bit, odd parity, two stop bits; frame = 11*DIV2 cycles.
      c2[0] = 14'h3FFF; e2[0] = 22'b11011111110_11011111110;
      c2[1] = 14'h1FFF; e2[1] = 22'b11011111110_11101111110;
      for (int k = 0; k < 2; k++) begin
         cmd2_in = c2[k]; cmd2_vld = 1'b1; line = '0;
         for (int c = 1; c <= 221; c++) begin
            @(negedge clk);
            if (c == 1) begin
               chk("t2_start", tx2, 1'b0);
               cmd2_vld = 1'b0;
            end
            if ((c - 1) % DIV2 == DIV2 / 2 && (c - 1) / DIV2 < 22) line[(c - 1) / DIV2] = tx2;
            if (c == 220) chk("t2_rdy_220", cmd2_rdy, 1'b0);
            if (c == 221) chk("t2_rdy_221", cmd2_rdy, 1'b1);
         end
         chk("t2_line", line, e2[k]);
         repeat (20) @(negedge clk);
      end
      chk("t2_rx_count", rx2q.size(), 4);
      if (rx2q.size() == 4) begin
         chk("t2_rx0", rx2q[0], 9'h07F);
         chk("t2_rx1", rx2q[1], 9'h07F);
         chk("t2_rx2", rx2q[2], 9'h03F);
         chk("t2_rx3", rx2q[3], 9'h07F);
      end

      // Loopback with cmd_vld held high across three random commands.
      loop_en = 1'b1;
      rxq.delete(); rxt.delete();
      for (int k = 0; k < 3; k++) cmds[k] = 16'($urandom);
      cmd_in = cmds[0]; cmd_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!cmd_rdy && n < 12000) begin
            @(negedge clk);
            n++;
         end
         chk("lb_rdy_wait", cmd_rdy, 1'b1);
         tk[k] = cyc;
         if (k > 0) chk("lb_spacing", tk[k] - tk[k-1], 9549);
         @(negedge clk);
         if (k < 2) cmd_in = cmds[k+1];
         else cmd_vld = 1'b0;
      end
      n = 0;
      while (rxq.size() < 6 && n < 12000) begin
         @(negedge clk);
         n++;
      end
      chk("lb_rx_count", rxq.size(), 6);
      if (rxq.size() == 6) begin
         for (int k = 0; k < 3; k++) begin
            chk("lb_word_hi", rxq[2*k],     {2'b00, cmds[k][15:8]});
            chk("lb_word_lo", rxq[2*k + 1], {2'b00, cmds[k][7:0]});
         end
      end
      repeat (10) @(negedge clk);
      loop_en = 1'b0;

      // Injected frames: bad parity, then bad stop bit.
      rxq.delete(); rxt.delete();
      fall_cyc = cyc;
      drive_frame(8'h55, 1'b1, 1'b1);
      repeat (DIV1) @(negedge clk);
      chk("inj_perr_count", rxq.size(), 1);
      if (rxq.size() >= 1) begin
         chk("inj_perr_word", rxq[0], 10'h155);
         lat = rxt[0] - fall_cyc;
         chk("inj_latency", (lat >= 4555 && lat <= 4566), 1'b1);
      end
      drive_frame(8'hC3, 1'b0, 1'b0);
      repeat (DIV1) @(negedge clk);
      chk("inj_ferr_count", rxq.size(), 2);
      if (rxq.size() >= 2) chk("inj_ferr_word", rxq[1], 10'h2C3);

      // Short low glitch must be rejected; a following good frame still lands.
      rx_drv = 1'b0;
      repeat (130) @(negedge clk);
      rx_drv = 1'b1;
      repeat (900) @(negedge clk);
      chk("glitch_no_vld", rxq.size(), 2);
      drive_frame(8'hA7, 1'b1, 1'b1);
      repeat (DIV1) @(negedge clk);
      chk("glitch_next_count", rxq.size(), 3);
      if (rxq.size() >= 3) chk("glitch_next_word", rxq[2], 10'h0A7);

      // Reset in the middle of a command, then a fresh command starts from word 0.
      cmd_in = 16'h1234; cmd_vld = 1'b1;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (c == 1) cmd_vld = 1'b0;
      end
      chk("rstmid_tx_before", tx, 1'b0);
      rst = 1'b1;
      #1;
      chk("rstmid_tx", tx, 1'b1);
      chk("rstmid_rdy", cmd_rdy, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cmd_in = 16'h8001; cmd_vld = 1'b1; line = '0;
      for (int c = 1; c <= 11 * DIV1; c++) begin
         @(negedge clk);
         if (c == 1) cmd_vld = 1'b0;
         if ((c - 1) % DIV1 == DIV1 / 2) line[(c - 1) / DIV1] = tx;
      end
      chk("rstmid_new_frame", line[10:0], 11'b11100000000);
      n = 0;
      while (!cmd_rdy && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_done", cmd_rdy, 1'b1);
      chk("rstmid_no_rx", rxq.size(), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
